dm_store_buf: RTL and testbench
===============================

DM_STORE_BUF -- requirements
Module: dm_store_buf

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered store entries; legal values 2 and 4 only.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 st_valid  in  1  store request present this cycle.
REQ-005 st_op  in  3  store width: 1=word (sw), 2=half (sh), 3=byte (sb); any other value is a no-op.
REQ-006 st_addr  in  32  byte address of the store.
REQ-007 st_data  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-008 st_ready  out  1  buffer can accept a request this cycle.
REQ-009 exc_ades  out  1  one-cycle pulse flagging a misaligned store that was dropped.
REQ-010 mem_req  out  1  head entry presented to data memory.
REQ-011 mem_addr  out  32  word address, {addr[31:2],2'b00}.
REQ-012 mem_byteen  out  4  byte-lane write enables, bit i = byte lane [8i+7:8i].
REQ-013 mem_wdata  out  32  lane-aligned write data.
REQ-014 mem_ack  in  1  memory consumed the head entry this cycle.
REQ-015 empty  out  1  no entries held; used by the pipeline to drain before a load.

Function
REQ-016 st_ready SHALL be 1 when count < DEPTH, and SHALL be driven combinationally from count only.
REQ-017 A request SHALL be accepted when st_valid & st_ready & st_op in {1,2,3} & aligned.
REQ-018 Aligned rule: word requires addr[1:0]=00; half requires addr[0]=0; byte is always aligned.
REQ-019 A misaligned request with st_valid & st_ready SHALL NOT be enqueued; exc_ades SHALL be 1 in the following cycle only.
REQ-020 st_op not in {1,2,3} SHALL be ignored: no enqueue, no exc_ades.
REQ-021 Byte enables: word 1111; half 0011 if addr[1]=0, else 1100; byte 0001 shifted left by addr[1:0].
REQ-022 Write data: word st_data; half {st_data[15:0],st_data[15:0]}; byte st_data[7:0] replicated 4 times.
REQ-023 Entries SHALL hold the aligned word address, byteen and wdata, computed at enqueue.
REQ-024 FIFO order: entries SHALL issue to memory in acceptance order.
REQ-025 mem_req SHALL equal (count != 0); mem_addr/byteen/wdata SHALL show the head entry, registered.
REQ-026 While mem_req & !mem_ack, all mem_* outputs SHALL hold stable.
REQ-027 mem_req & mem_ack SHALL pop the head; the next entry appears in the following cycle.
REQ-028 mem_ack while mem_req=0 SHALL be ignored.
REQ-029 Latency: a store accepted in cycle N into an empty buffer SHALL raise mem_req in cycle N+1.
REQ-030 A push and a pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-031 When full, a pop SHALL raise st_ready in the next cycle; there is no same-cycle bypass.
REQ-032 When count=0, mem_addr, mem_byteen and mem_wdata SHALL be 0.
REQ-033 Read/write pointers SHALL wrap modulo DEPTH.
REQ-034 empty SHALL equal (count == 0).

Reset
REQ-035 reset SHALL clear count and both pointers and discard all pending entries, including one mid-handshake.
REQ-036 In the cycle after reset, outputs SHALL be: st_ready=1, exc_ades=0, mem_req=0, mem_addr=0, mem_byteen=0, mem_wdata=0, empty=1.
REQ-037 A request presented in a cycle where reset=1 SHALL be dropped.

Structure
REQ-038 A shared package SHALL hold the ST_OP_W=1, ST_OP_H=2 and ST_OP_B=3 codes and the default DEPTH.
REQ-039 Byte-enable and data alignment SHALL live in one combinational sub-module, store_align (inputs op, addr[1:0], data; outputs byteen, wdata).
REQ-040 The remaining RTL SHALL be the FIFO storage, the pointers and count, and the exc_ades register.

Verification
REQ-041 sb addr=0x0000_1003 data=0x0000_00AB, mem_ack=1 -> next cycle mem_req=1, addr=0x1000, byteen=1000, wdata=0xABABABAB.
REQ-042 sh addr=0x2002 data=0x1234 -> byteen=1100, wdata=0x12341234; sw addr=0x2002 -> exc_ades pulse for one cycle, no mem_req.
REQ-043 mem_ack=0, three sw requests back-to-back (DEPTH=2) -> st_ready=0 after two accepts, third request held, mem_* stable throughout.
REQ-044 When full, assert mem_ack for one cycle -> head pops, st_ready=1 next cycle, second entry shown; order preserved across pointer wrap over 6 stores.
REQ-045 Reset while mem_req=1 and count=2 -> next cycle all outputs at reset values, empty=1.
REQ-046 Push and pop in the same cycle with count=1 -> count stays 1, new entry appears next.

Source files
------------

// File: rtl/dm_store_buf_pkg.sv
// Shared store-op codes, the buffered entry format and alignment helpers
// for the data-memory store buffer.
package dm_store_buf_pkg;

    localparam logic [2:0] ST_OP_W = 3'd1;
    localparam logic [2:0] ST_OP_H = 3'd2;
    localparam logic [2:0] ST_OP_B = 3'd3;

    localparam int DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
    } st_entry_t;

    function automatic logic is_store_op(input logic [2:0] op);
        return (op == ST_OP_W) || (op == ST_OP_H) || (op == ST_OP_B);
    endfunction

    // Bytes are always aligned; unknown ops report aligned so they never raise exc_ades.
    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            ST_OP_W: return addr_lo == 2'b00;
            ST_OP_H: return addr_lo[0] == 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_store_buf_store_align.sv
// Lane alignment of a store: byte enables and replicated write data
// derived from the op, the low address bits and the right-justified data.
module store_align
    import dm_store_buf_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [3:0]  byteen,
    output logic [31:0] wdata
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        byteen = 4'b0000;
        wdata  = 32'h0;
        case (op)
            ST_OP_W: begin
                byteen = 4'b1111;
                wdata  = data;
            end
            ST_OP_H: begin
                byteen = addr[1] ? 4'b1100 : 4'b0011;
                wdata  = {data[15:0], data[15:0]};
            end
            ST_OP_B: begin
                byteen = 4'b0001 << addr;
                wdata  = {4{data[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_store_buf.sv
// In-order store buffer between the pipeline and data memory: aligned stores
// are queued and presented head-first through registered mem_* outputs.
module dm_store_buf
    import dm_store_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [2:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        exc_ades,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    st_entry_t        head_q, head_d;
    logic             exc_q, exc_d;
    st_entry_t        entries_q [DEPTH];
    st_entry_t        new_entry;
    logic             push, pop, op_ok, aligned;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    store_align u_align (
        .op     (st_op),
        .addr   (st_addr[1:0]),
        .data   (st_data),
        .byteen (new_entry.byteen),
        .wdata  (new_entry.wdata)
    );

    assign new_entry.addr = {st_addr[31:2], 2'b00};

    assign st_ready = count_q < CNT_W'(DEPTH);
    assign mem_req  = count_q != '0;
    assign empty    = count_q == '0;
    assign op_ok    = is_store_op(st_op);
    assign aligned  = is_aligned(st_op, st_addr[1:0]);
    assign push     = st_valid & st_ready & op_ok & aligned;
    assign pop      = mem_req & mem_ack;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        exc_d    = st_valid & st_ready & op_ok & ~aligned;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The slot being written becomes the head when the buffer was empty or drains to it.
        if (count_d == '0)
            head_d = '0;
        else if (push && (wr_ptr_q == rd_ptr_d))
            head_d = new_entry;
        else
            head_d = entries_q[rd_ptr_d];
    end

    // NOTE: entry storage has no reset; count and pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (push)
            entries_q[wr_ptr_q] <= new_entry;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            head_q   <= '0;
            exc_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            head_q   <= head_d;
            exc_q    <= exc_d;
        end
    end

    assign exc_ades   = exc_q;
    assign mem_addr   = head_q.addr;
    assign mem_byteen = head_q.byteen;
    assign mem_wdata  = head_q.wdata;

endmodule

// File: tb/tb_dm_store_buf.sv
// Directed self-checking bench for dm_store_buf with DEPTH=2: alignment,
// misalignment pulse, back-pressure, FIFO order across wrap, push+pop, reset.
module tb_dm_store_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [2:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        exc_ades;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        empty;

    int checks = 0;
    int errors = 0;

    dm_store_buf dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_op      (st_op),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .exc_ades   (exc_ades),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        st_valid = v;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".st_ready"}, st_ready, 1);
        check({tag, ".exc_ades"}, exc_ades, 0);
        check({tag, ".mem_req"},  mem_req,  0);
        check({tag, ".mem_addr"}, mem_addr, 0);
        check({tag, ".byteen"},   mem_byteen, 0);
        check({tag, ".wdata"},    mem_wdata, 0);
        check({tag, ".empty"},    empty, 1);
    endtask

    task automatic check_head(input string tag, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] d);
        check({tag, ".mem_req"}, mem_req, 1);
        check({tag, ".addr"},    mem_addr, a);
        check({tag, ".byteen"},  mem_byteen, be);
        check({tag, ".wdata"},   mem_wdata, d);
    endtask

    initial begin
        reset   = 1'b1;
        mem_ack = 1'b0;
        drive(0, 3'd0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("rst");

        // Byte store; ack while idle must be ignored
        drive(1, 3'd3, 32'h0000_1003, 32'h0000_00AB);
        mem_ack = 1'b1;
        tick();
        drive(0, 3'd0, 32'h0, 32'h0);
        check_head("sb", 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
        check("sb.empty", empty, 0);
        tick();
        check("sb_pop.mem_req", mem_req, 0);
        check("sb_pop.addr", mem_addr, 0);

        // Upper half, then misaligned word dropped while the half pops
        mem_ack = 1'b0;
        drive(1, 3'd2, 32'h0000_2002, 32'h0000_1234);
        tick();
        check_head("sh", 32'h0000_2000, 4'b1100, 32'h1234_1234);
        drive(1, 3'd1, 32'h0000_2002, 32'h5555_5555);
        mem_ack = 1'b1;
        tick();
        check("ades.exc", exc_ades, 1);
        check("ades.mem_req", mem_req, 0);
        drive(0, 3'd0, 32'h0, 32'h0);
        mem_ack = 1'b0;
        tick();
        check("ades_pulse.exc", exc_ades, 0);
        check("ades_pulse.mem_req", mem_req, 0);

        // Unknown op is a no-op; misaligned half raises exc
        drive(1, 3'd5, 32'h0000_3000, 32'h1);
        tick();
        check("noop.exc", exc_ades, 0);
        check("noop.mem_req", mem_req, 0);
        drive(1, 3'd2, 32'h0000_3001, 32'h1);
        tick();
        check("sh_mis.exc", exc_ades, 1);
        check("sh_mis.empty", empty, 1);

        // Back-pressure: third word held while full
        drive(1, 3'd1, 32'h0000_0100, 32'h1111_1111);
        tick();
        check_head("bp1", 32'h0000_0100, 4'b1111, 32'h1111_1111);
        check("bp1.st_ready", st_ready, 1);
        drive(1, 3'd1, 32'h0000_0104, 32'h2222_2222);
        tick();
        check("bp2.st_ready", st_ready, 0);
        check_head("bp2", 32'h0000_0100, 4'b1111, 32'h1111_1111);
        drive(1, 3'd1, 32'h0000_0108, 32'h3333_3333);
        tick();
        check("bp3.st_ready", st_ready, 0);
        check_head("bp3", 32'h0000_0100, 4'b1111, 32'h1111_1111);

        // Pop from full: no bypass, held request enters the cycle after
        mem_ack = 1'b1;
        tick();
        check("full_pop.st_ready", st_ready, 1);
        check_head("full_pop", 32'h0000_0104, 4'b1111, 32'h2222_2222);
        mem_ack = 1'b0;
        tick();
        check("refill.st_ready", st_ready, 0);
        check_head("refill", 32'h0000_0104, 4'b1111, 32'h2222_2222);
        drive(0, 3'd0, 32'h0, 32'h0);
        mem_ack = 1'b1;
        tick();
        check_head("drain1", 32'h0000_0108, 4'b1111, 32'h3333_3333);
        tick();
        check("drain2.empty", empty, 1);
        mem_ack = 1'b0;

        // Six words in pairs: pointers wrap three times
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 2; k++) begin
                drive(1, 3'd1, 32'h0000_4000 + 32'(4 * (2 * p + k)), 32'(2 * p + k) * 32'h0101_0101);
                tick();
            end
            drive(0, 3'd0, 32'h0, 32'h0);
            check_head($sformatf("wrap%0d.a", p), 32'h0000_4000 + 32'(8 * p), 4'b1111,
                       32'(2 * p) * 32'h0101_0101);
            mem_ack = 1'b1;
            tick();
            check_head($sformatf("wrap%0d.b", p), 32'h0000_4004 + 32'(8 * p), 4'b1111,
                       32'(2 * p + 1) * 32'h0101_0101);
            tick();
            check($sformatf("wrap%0d.empty", p), empty, 1);
            mem_ack = 1'b0;
        end

        // Push and pop in the same cycle with one entry held
        drive(1, 3'd3, 32'h0000_0501, 32'h0000_005A);
        tick();
        check_head("pp_a", 32'h0000_0500, 4'b0010, 32'h5A5A_5A5A);
        drive(1, 3'd2, 32'h0000_0600, 32'h0000_BEEF);
        mem_ack = 1'b1;
        tick();
        check_head("pp_b", 32'h0000_0600, 4'b0011, 32'hBEEF_BEEF);
        check("pp_b.st_ready", st_ready, 1);
        check("pp_b.empty", empty, 0);
        drive(0, 3'd0, 32'h0, 32'h0);
        tick();
        check("pp_done.empty", empty, 1);
        mem_ack = 1'b0;

        // Reset while full and mid-handshake, with a request that must be dropped
        drive(1, 3'd1, 32'h0000_0700, 32'h7);
        tick();
        drive(1, 3'd1, 32'h0000_0704, 32'h8);
        tick();
        check("pre_rst.st_ready", st_ready, 0);
        check("pre_rst.mem_req", mem_req, 1);
        reset   = 1'b1;
        mem_ack = 1'b1;
        drive(1, 3'd3, 32'h0000_0800, 32'h9);
        tick();
        reset   = 1'b0;
        mem_ack = 1'b0;
        drive(0, 3'd0, 32'h0, 32'h0);
        check_reset_state("mid_rst");
        tick();
        check_reset_state("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
